// File: rtl/arbitro_mux_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encodings,
// the default hold limit and the priority/grant helper functions.
package arbitro_mux_4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TROCA = 2'b10
    } state_t;

    localparam int MAX_HOLD_DEFAULT = 8;

    // Scan from the far end back toward ptr so the closest set bit wins.
    function automatic logic [1:0] first_req(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        first_req = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) first_req = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4x1_n.sv
// Four-input, N-bit wide combinational multiplexer.
module mux_4x1_n #(
    parameter int N = 4
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [N-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/arbitro_mux_4.sv
// Round-robin arbiter for four requesters with a bounded hold time, steering
// the owner's data through a shared mux into a registered output.
module arbitro_mux_4
    import arbitro_mux_4_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      REQ,
    input  logic [BITS-1:0] D3,
    input  logic [BITS-1:0] D2,
    input  logic [BITS-1:0] D1,
    input  logic [BITS-1:0] D0,
    output logic [3:0]      GNT,
    output logic [1:0]      SEL,
    output logic [BITS-1:0] DATA_OUT,
    output logic            VALID,
    output logic            BUSY,
    output state_t          dbg_state
);

    // REQ/GNT handshake: a requester holds REQ[i] high until done; ownership
    // starts on the edge GNT[i] rises and ends when REQ[i] drops or the hold
    // limit expires with a competitor waiting. DATA_OUT is meaningful only
    // while VALID is high.
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   cnt;
    logic [1:0]      winner;
    logic            others_req;
    logic [BITS-1:0] mux_y;

    mux_4x1_n #(.N(BITS)) u_mux (
        .sel (SEL),
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .y   (mux_y)
    );

    always_comb begin
        winner     = first_req(REQ, ptr);
        others_req = |(REQ & ~onehot(SEL));
    end

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            GNT      <= '0;
            SEL      <= '0;
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    GNT   <= '0;
                    VALID <= 1'b0;
                    if (|REQ) begin
                        state <= GRANT;
                        SEL   <= winner;
                        GNT   <= onehot(winner);
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                GRANT: begin
                    // A lone owner keeps the grant; the saturated counter only bites once someone else asks.
                    if (!REQ[SEL] || (cnt == HOLD_LAST && others_req)) begin
                        state <= TROCA;
                        GNT   <= '0;
                        VALID <= 1'b0;
                        ptr   <= SEL + 2'd1;
                    end else begin
                        DATA_OUT <= mux_y;
                        VALID    <= 1'b1;
                        if (cnt != HOLD_LAST) cnt <= cnt + 1'b1;
                    end
                end
                TROCA: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
